// File: rtl/iecdrv_pkg.sv
// Shared types and constants for the drive ROM time-slot arbiter.
// Imported by the arbiter top and its tag pipeline.
package iecdrv_pkg;

  localparam int unsigned MAX_DRIVES = 8;
  localparam int unsigned MAX_BANKS  = 8;
  localparam int unsigned ROM_AW     = 15;

  typedef logic [2:0] rom_bank_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } arb_state_t;

  localparam logic [1:0] ROM_SZ_8K  = 2'b00;
  localparam logic [1:0] ROM_SZ_16K = 2'b01;
  localparam logic [1:0] ROM_SZ_32K = 2'b11;

  // Returns {bit14 enable, bit13 enable}. stdrom keeps bit 13 alive for small images.
  function automatic logic [1:0] hi_bit_en(input logic [1:0] rom_sz, input logic stdrom);
    return {rom_sz[1], rom_sz[0] | stdrom};
  endfunction

endpackage

// File: rtl/iecdrv_tag_pipe.sv
// Delay line carrying {valid, slot, invalid-bank} alongside an outstanding ROM read,
// so the capture stage knows which drive register the returning byte belongs to.
module iecdrv_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned SW    = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [SW-1:0] i_slot,
  input  logic          i_inv,
  output logic          o_valid,
  output logic [SW-1:0] o_slot,
  output logic          o_inv
);

  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0]         r_inv;
  logic [DEPTH-1:0][SW-1:0] r_slot;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_inv   <= '0;
      r_slot  <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_inv[0]   <= i_inv;
      r_slot[0]  <= i_slot;
      for (int unsigned s = 1; s < DEPTH; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_inv[s]   <= r_inv[s-1];
        r_slot[s]  <= r_slot[s-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_slot  = r_slot[DEPTH-1];
  assign o_inv   = r_inv[DEPTH-1];

endmodule

// File: rtl/iecdrv_rom_arbiter.sv
// Time-slot arbiter sharing one ROM store among up to 8 drive CPUs: each ph2_f starts a
// sweep issuing one read per drive and returning each byte to that drive's data register.
module iecdrv_rom_arbiter
  import iecdrv_pkg::*;
#(
  parameter int unsigned NDR   = 4,
  parameter int unsigned NBANK = 4,
  parameter int unsigned AW    = 15,
  parameter int unsigned RDLAT = 1,
  localparam int unsigned BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_ph2_f,
  input  logic [NDR-1:0][AW-1:0]  i_drv_addr,
  input  logic [NDR-1:0][BW-1:0]  i_drv_bank,
  input  logic [1:0]              i_rom_sz,
  input  logic                    i_stdrom,
  output logic [BW+AW-1:0]        o_mem_addr,
  input  logic [7:0]              i_mem_q,
  output logic [NDR-1:0][7:0]     o_drv_data,
  output logic [NDR-1:0]          o_drv_valid,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int unsigned SW = (NDR > 1) ? $clog2(NDR) : 1;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [SW-1:0]         r_slot;
  logic [1:0]            r_drain;
  logic [BW+AW-1:0]      r_mem_addr;
  logic                  r_overrun;
  logic [NDR-1:0][7:0]   r_drv_data;
  logic [NDR-1:0]        r_drv_valid;

  logic                  w_last_slot;
  logic                  w_drain_done;
  logic                  w_issue;
  logic [1:0]            w_hi_en;
  logic [AW-1:0]         w_raw_addr;
  logic [AW-1:0]         w_addr_mask;
  logic [BW-1:0]         w_bank;
  logic                  w_bank_inv;
  logic [BW-1:0]         w_bank_eff;
  logic                  w_cap_valid;
  logic [SW-1:0]         w_cap_slot;
  logic                  w_cap_inv;

  assign w_last_slot  = (r_slot == SW'(NDR - 1));
  assign w_drain_done = (r_state == DRAIN) && (r_drain == 2'(RDLAT - 1));
  assign w_issue      = (r_state == ISSUE);

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (i_ph2_f) w_state_nxt = ISSUE;
      ISSUE: if (w_last_slot) w_state_nxt = DRAIN;
      DRAIN: begin
        // A strobe landing on the final drain clock starts the next sweep directly.
        if (w_drain_done) w_state_nxt = i_ph2_f ? ISSUE : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_mem_addr  = r_mem_addr;
    o_overrun   = r_overrun;
    o_drv_data  = r_drv_data;
    o_drv_valid = r_drv_valid;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_slot  <= '0;
      r_drain <= '0;
    end else begin
      if (w_issue && !w_last_slot) begin
        r_slot <= r_slot + SW'(1);
      end else begin
        r_slot <= '0;
      end
      if ((r_state == DRAIN) && !w_drain_done) begin
        r_drain <= r_drain + 2'd1;
      end else begin
        r_drain <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (i_ph2_f && (r_state != IDLE) && !w_drain_done) begin
      r_overrun <= 1'b1;
    end
  end

  // Address masking uses the drive address as it stands in the issue cycle.
  always_comb begin
    w_hi_en     = hi_bit_en(i_rom_sz, i_stdrom);
    w_raw_addr  = i_drv_addr[r_slot];
    w_addr_mask = '0;
    for (int unsigned b = 0; b < AW; b++) begin
      if (b < 13) begin
        w_addr_mask[b] = w_raw_addr[b];
      end else if (b == 13) begin
        w_addr_mask[b] = w_raw_addr[b] & w_hi_en[0];
      end else if (b == ROM_AW - 1) begin
        w_addr_mask[b] = w_raw_addr[b] & w_hi_en[1];
      end
    end
  end

  assign w_bank     = i_drv_bank[r_slot];
  assign w_bank_inv = (32'(w_bank) >= NBANK);
  assign w_bank_eff = w_bank_inv ? '0 : w_bank;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_addr <= '0;
    end else if (w_issue) begin
      r_mem_addr <= {w_bank_eff, w_addr_mask};
    end
  end

  iecdrv_tag_pipe #(
    .DEPTH (RDLAT),
    .SW    (SW)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (w_issue),
    .i_slot  (r_slot),
    .i_inv   (w_bank_inv),
    .o_valid (w_cap_valid),
    .o_slot  (w_cap_slot),
    .o_inv   (w_cap_inv)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_drv_data  <= {NDR{8'hFF}};
      r_drv_valid <= '0;
    end else begin
      r_drv_valid <= '0;
      if (w_cap_valid) begin
        r_drv_data[w_cap_slot]  <= w_cap_inv ? 8'hFF : i_mem_q;
        r_drv_valid[w_cap_slot] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/iecdrv_rom_arbiter.md
Name: iecdrv_rom_arbiter

Overview:
- Time-slot arbiter that lets up to 8 drive CPUs share one external ROM store holding several ROM images (banks), e.g. 1541, 1571 and alternate images.
- Once per drive bus cycle, triggered by ph2_f, it issues one ROM read per drive.
- It returns each drive's byte in that drive's data register before the drive's next ph2_r.
- Parametrised successor to the fixed 4-drive / 2-image sharing scheme: adds configurable drive count, per-drive bank selection, configurable memory read latency, and overrun detection.

Parameters:
- NDR, 4: number of drives served; legal range 1..8.
- NBANK, 4: number of ROM images in the shared store; legal range 1..8.
- AW, 15: per-drive ROM byte address width (32K).
- RDLAT, 1: clocks from mem_addr to valid mem_q; legal range 1..3.

Ports:
- clk  in  1  drive clock (16 MHz domain).
- reset  in  1  asynchronous, active-high.
- ph2_f  in  1  one-clk strobe at the drive-CPU phase-2 falling edge; starts a sweep.
- drv_addr  in  NDR x AW  per-drive CPU ROM address.
- drv_bank  in  NDR x BW  per-drive ROM image select, BW = max(1, clog2(NBANK)).
- rom_sz  in  2  image size code: 00 = 8K, 01 = 16K, 11 = 32K.
- stdrom  in  1  forces address bit 13 through regardless of rom_sz.
- mem_addr  out  BW+AW  address to shared ROM: {bank, masked address}.
- mem_q  in  8  shared ROM read data.
- drv_data  out  NDR x 8  per-drive ROM byte, held between captures.
- drv_valid  out  NDR  one-clk pulse when drv_data[k] is updated.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky flag: ph2_f arrived while busy.

Behaviour:
- Reset values: mem_addr = 0, all drv_data = 8'hFF, drv_valid = 0, busy = 0, overrun = 0, FSM in IDLE, slot counter = 0.
- Reset asserted mid-sweep aborts immediately. No further captures occur after reset deasserts until the next ph2_f.
- FSM states:
  - IDLE: on ph2_f, go to ISSUE with slot = 0 and busy <= 1.
  - ISSUE: each clk, drive mem_addr for the current slot and slot++. After slot NDR-1 has been issued, go to DRAIN.
  - DRAIN: wait RDLAT clks until the last capture completes, then go to IDLE with busy <= 0.
- Address masking, applied in the ISSUE cycle (drv_addr is sampled in that cycle, not at ph2_f):
  - bit14 = a[14] & rom_sz[1].
  - bit13 = a[13] & (rom_sz[0] | stdrom).
  - bits 12..0 pass through.
  - Bits above 14 (when AW > 15) are forced to 0.
- Bank handling: bank field = drv_bank[slot]. If drv_bank[slot] >= NBANK, issue bank 0 and flag that slot as invalid-bank.
- Pipeline: {slot, invalid-bank} travels an RDLAT-deep shift register alongside the read.
  - When it emerges, drv_data[slot] <= invalid ? 8'hFF : mem_q, and drv_valid[slot] pulses for 1 clk.
- Latency:
  - Drive k is issued at clk ph2_f+1+k.
  - Drive k is captured at clk ph2_f+1+k+RDLAT.
  - Full sweep = NDR+RDLAT clks after ph2_f.
- Bandwidth constraint: with ph2 period 16 clks, NDR+RDLAT <= 15 always holds for legal parameters.
- ph2_f while busy: the sweep is not restarted, the strobe is dropped, and overrun <= 1. overrun is cleared only by reset.
- ph2_f on the same clk the FSM returns to IDLE: accepted, and a new sweep begins on the next clk.
- Slot counter wraps to 0 only through IDLE. It never exceeds NDR-1.
- NDR = 1 degenerates to a single issue followed by RDLAT drain. No special case is required.
- drv_data for a drive not yet captured after reset reads 8'hFF.

Decomposition:
- Package iecdrv_pkg holds:
  - MAX_DRIVES = 8, MAX_BANKS = 8, ROM_AW = 15.
  - Typedef rom_bank_t = logic [2:0].
  - The FSM enum arb_state_t {IDLE, ISSUE, DRAIN}.
  - The rom_sz encodings as named constants.
- One sub-module: iecdrv_tag_pipe, a parametrised RDLAT-stage shift register with async reset carrying {valid, slot, invalid-bank}. It is reused for the capture path.

Test Plan:
- NDR = 4, RDLAT = 1; ROM model returns the low byte of the address; drv_addr = 0x0010/0x0020/0x0030/0x0040; rom_sz = 11; single ph2_f:
  - drv_data = 10/20/30/40, each drv_valid pulsing at clk +2..+5.
  - busy high for exactly 5 clks.
- drv_addr = 0x7FFF, rom_sz = 00:
  - stdrom = 0 gives mem_addr low 15 bits = 0x1FFF.
  - stdrom = 1 gives 0x3FFF.
  - rom_sz = 01, stdrom = 0 gives 0x3FFF.
- NBANK = 3, drv_bank[2] = 3 (invalid):
  - mem_addr bank field = 0 during slot 2.
  - drv_data[2] = FF while the other drives get ROM data.
- NDR = 8, RDLAT = 3; second ph2_f 5 clks after the first:
  - overrun = 1.
  - All 8 drives still captured once, busy high for 11 clks, no restart.
- Reset asserted at clk +3 of a sweep: all drv_data = FF, busy = 0, and no drv_valid pulses after reset release until the next ph2_f.
- ph2_f coincident with the DRAIN→IDLE clk: the next sweep starts on the following clk, and overrun stays 0.
